// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - shared constants for the emulated logic-part library
package logic_pkg;

  localparam int LOGIC_SYNC_STAGES_DEF = 2;
  localparam int LOGIC_BUS_W           = 8;

endpackage

// File: rtl/pin_sync.sv
// rtl/pin_sync.sv - multi-bit chip-pin synchronizer with per-instance reset value
module pin_sync
  import logic_pkg::*;
#(
  parameter int            W       = 1,
  parameter int            STAGES  = LOGIC_SYNC_STAGES_DEF,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // Fewer than two flops would not resolve metastability, so clamp upward.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [W-1:0] r_stage [N];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N; i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < N; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[N-1];

endmodule

// File: rtl/logic_74hc165.sv
// rtl/logic_74hc165.sv - clocked 74HC165 parallel-in/serial-out shift register
module logic_74hc165
  import logic_pkg::*;
#(
  parameter int WIDTH       = LOGIC_BUS_W,
  parameter int SYNC_STAGES = LOGIC_SYNC_STAGES_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             nPL,
  input  logic             CP,
  input  logic             nCE,
  input  logic             DS,
  output logic             Q7,
  output logic             nQ7
);

  logic [WIDTH-1:0] w_d_s;
  logic             w_ds_s;
  logic             w_npl_s;
  logic             w_cp_s;
  logic             w_nce_s;
  logic             w_ceff;
  logic             w_rise;

  logic             r_prev_ceff;
  logic [WIDTH-1:0] r_shift;

  pin_sync #(
    .W       (WIDTH + 1),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ('0)
  ) u_sync_data (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   ({D, DS}),
    .o_q   ({w_d_s, w_ds_s})
  );

  pin_sync #(
    .W       (1),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_npl (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (nPL),
    .o_q   (w_npl_s)
  );

  // Clock pins reset high so a pin already low at release never looks like an edge.
  pin_sync #(
    .W       (2),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (2'b11)
  ) u_sync_clk (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   ({CP, nCE}),
    .o_q   ({w_cp_s, w_nce_s})
  );

  assign w_ceff = w_cp_s | w_nce_s;
  assign w_rise = w_ceff & ~r_prev_ceff;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prev_ceff <= 1'b1;
      r_shift     <= '0;
    end else begin
      r_prev_ceff <= w_ceff;
      if (!w_npl_s) begin
        r_shift <= w_d_s;
      end else if (w_rise) begin
        r_shift <= {r_shift[WIDTH-2:0], w_ds_s};
      end
    end
  end

  assign Q7  = r_shift[WIDTH-1];
  assign nQ7 = ~r_shift[WIDTH-1];

endmodule

// File: tb/tb_logic_74hc165.sv
// tb/tb_logic_74hc165.sv - directed scoreboard bench for logic_74hc165
module tb_logic_74hc165;

  localparam int W  = 8;
  localparam int SS = 2;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] D   = '0;
  logic         nPL = 1'b1;
  logic         CP  = 1'b1;
  logic         nCE = 1'b0;
  logic         DS  = 1'b0;
  logic         Q7;
  logic         nQ7;

  logic_74hc165 #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .CLK (CLK),
    .RST (RST),
    .D   (D),
    .nPL (nPL),
    .CP  (CP),
    .nCE (nCE),
    .DS  (DS),
    .Q7  (Q7),
    .nQ7 (nQ7)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;

  sb_t        sb_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] m      = '0;

  function automatic logic [9:0] reg_word(input logic [7:0] v);
    return {v[7], ~v[7], v};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input string tag, input logic [9:0] e);
    sb_t item;
    item.tag = tag;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  task automatic sb_check(input logic [9:0] obs);
    sb_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %h, no expected entry queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic check_reg();
    sb_check({Q7, nQ7, dut.r_shift});
  endtask

  task automatic expect_reg(input string tag);
    push(tag, reg_word(m));
    check_reg();
  endtask

  task automatic pulse();
    CP = 1'b0;
    cycles(3);
    CP = 1'b1;
    cycles(3);
  endtask

  task automatic shift_model();
    m = {m[6:0], DS};
  endtask

  task automatic load(input logic [7:0] v);
    nPL = 1'b0;
    D   = v;
    cycles(4);
    nPL = 1'b1;
    cycles(SS + 1);
    m = v;
  endtask

  initial begin
    int lat;

    // Reset with CP high, nCE low and DS high: any spurious edge would shift in a 1.
    RST = 1'b1; CP = 1'b1; nCE = 1'b0; nPL = 1'b1; DS = 1'b1;
    cycles(3);
    m = 8'h00;
    expect_reg("rst_state");
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      expect_reg("no_shift_after_rst");
    end

    // Load A5 then shift out with DS=0; expected Q7 stream queued up front.
    DS = 1'b0;
    load(8'hA5);
    begin
      logic [7:0] t;
      t = 8'hA5;
      for (int i = 0; i < 9; i++) begin
        push("shift_a5", reg_word(t));
        t = {t[6:0], 1'b0};
      end
    end
    for (int i = 0; i < 9; i++) begin
      check_reg();
      if (i < 8) begin
        pulse();
        shift_model();
      end
    end

    // Clock inhibit.
    load(8'hFF);
    nCE = 1'b1;
    cycles(3);
    for (int i = 0; i < 8; i++) pulse();
    expect_reg("inhibit_8_pulses");
    nCE = 1'b0;
    cycles(4);
    expect_reg("nce_fall_cp_high");
    CP = 1'b0;
    cycles(3);
    expect_reg("cp_fall_no_shift");
    nCE = 1'b1;
    cycles(3);
    shift_model();
    expect_reg("nce_rise_cp_low");
    CP = 1'b1;
    cycles(3);
    nCE = 1'b0;
    cycles(3);
    expect_reg("nce_fall_after");

    // Shift in ones, then parallel load overrides pulses.
    load(8'h00);
    DS = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse();
      shift_model();
    end
    expect_reg("ds_ones_07");
    nPL = 1'b0;
    D   = 8'h80;
    cycles(3);
    pulse();
    pulse();
    m = 8'h80;
    expect_reg("npl_low_pulses");
    nPL = 1'b1;
    cycles(3);
    expect_reg("npl_release");

    // Asynchronous reset in the middle of a shift sequence.
    DS = 1'b0;
    load(8'h81);
    for (int i = 0; i < 4; i++) begin
      pulse();
      shift_model();
    end
    expect_reg("shift4_81");
    CP = 1'b0;
    cycles(1);
    #2 RST = 1'b1;
    #1;
    m = 8'h00;
    expect_reg("async_rst");
    cycles(2);
    RST = 1'b0;
    cycles(3);
    DS = 1'b1;
    pulse();
    shift_model();
    expect_reg("post_rst_shift");

    // Load latency from pin change to Q7.
    DS = 1'b0;
    load(8'h00);
    expect_reg("lat_pre");
    D = 8'h80;
    cycles(3);
    nPL = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      if (Q7 !== 1'b1) begin
        cycles(1);
        lat++;
      end
    end
    push("load_latency", 10'(SS + 1));
    sb_check(10'(lat));
    nPL = 1'b1;
    cycles(3);
    m = 8'h80;
    expect_reg("lat_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
